stack_alu_sequencer: RTL and testbench

STACK_ALU_SEQUENCER -- requirements
Module: stack_alu_sequencer

---
 rtl/stack_pkg.sv | 29 ++
 rtl/stack_alu_sequencer_if.sv | 28 ++
 rtl/operand_stack.sv | 48 ++++
 rtl/stack_alu_sequencer.sv | 105 ++++++++++
 tb/tb_stack_alu_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared opcode encodings (matching the external ALU) and sequencer state encodings.
package stack_pkg;

  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_B,
    S_FETCH_A,
    S_EXEC,
    S_WB
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= OP_PUSH) && (op <= OP_AND);
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_AND);
  endfunction

endpackage

// File: rtl/stack_alu_sequencer_if.sv
// Command/response bundle between a command source and the stack ALU sequencer.
interface stack_alu_sequencer_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] rd_data;
  logic             zero_flag;
  logic [CW-1:0]    depth;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, done, err, rd_data, zero_flag, depth
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, done, err, rd_data, zero_flag, depth
  );

endinterface

// File: rtl/operand_stack.sv
// DEPTH x WIDTH register stack: push, pop, or merge (replace top two entries with one).
module operand_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       merge,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           next,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      cnt;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    next_idx;

  // Indices wrap modulo DEPTH; the caller never pops empty or pushes full.
  assign top_idx  = cnt[PW-1:0] - PW'(1);
  assign next_idx = cnt[PW-1:0] - PW'(2);
  assign top      = mem[top_idx];
  assign next     = mem[next_idx];
  assign count    = cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (push) begin
      cnt <= cnt + (PW+1)'(1);
    end else if (pop || merge) begin
      cnt <= cnt - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[cnt[PW-1:0]] <= wdata;
    end else if (merge) begin
      mem[next_idx] <= wdata;
    end
  end

endmodule

// File: rtl/stack_alu_sequencer.sv
// Sequences stack commands: PUSH/POP directly, binary ops through an external ALU.
module stack_alu_sequencer
  import stack_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  stack_alu_sequencer_if.slave bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [3:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_zero
);
  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] stk_top, stk_next, wdata;
  logic [WIDTH-1:0] rd_q;
  logic             zero_q;
  logic [3:0]       op_q;
  logic             err_q;
  logic             accept, cmd_err, push_en, pop_en, merge_en;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    cmd_err = 1'b0;
    if (!is_legal_op(bus.cmd_op))     cmd_err = 1'b1;
    else if (bus.cmd_op == OP_PUSH)   cmd_err = (cnt == FULL);
    else if (bus.cmd_op == OP_POP)    cmd_err = (cnt == '0);
    else                              cmd_err = (cnt < CW'(2));
  end

  // Stack updates land on the edge entering WB so depth is current while done is high.
  assign push_en  = accept && !cmd_err && (bus.cmd_op == OP_PUSH);
  assign pop_en   = accept && !cmd_err && (bus.cmd_op == OP_POP);
  assign merge_en = (state == S_EXEC);
  assign wdata    = merge_en ? alu_result : bus.cmd_data;

  operand_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_en),
    .pop     (pop_en),
    .merge   (merge_en),
    .wdata   (wdata),
    .top     (stk_top),
    .next    (stk_next),
    .count   (cnt)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (accept) state_nxt = (cmd_err || !is_alu_op(bus.cmd_op)) ? S_WB : S_FETCH_B;
      S_FETCH_B: state_nxt = S_FETCH_A;
      S_FETCH_A: state_nxt = S_EXEC;
      S_EXEC:    state_nxt = S_WB;
      S_WB:      state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q   <= '0;
      err_q  <= 1'b0;
      alu_a  <= '0;
      alu_b  <= '0;
      rd_q   <= '0;
      zero_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.cmd_op;
        err_q <= cmd_err;
      end
      if (pop_en)              rd_q  <= stk_top;
      if (state == S_FETCH_B)  alu_b <= stk_top;
      if (state == S_FETCH_A)  alu_a <= stk_next;
      if (state == S_EXEC) begin
        rd_q   <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  assign bus.cmd_ready = (state == S_IDLE) && reset_n;
  assign bus.done      = (state == S_WB);
  assign bus.err       = (state == S_WB) && err_q;
  assign bus.rd_data   = rd_q;
  assign bus.zero_flag = zero_q;
  assign bus.depth     = cnt;
  assign alu_op        = (state == S_EXEC) ? op_q : 4'd0;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: directed scenarios plus random commands against a queue-based model.
module tb_stack_alu_sequencer;
  import stack_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [3:0]       alu_op;
  logic             alu_zero;

  stack_alu_sequencer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  stack_alu_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_OR:   return a | b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_NOR:  return ~(a | b);
      OP_AND:  return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // External ALU stand-in
  assign alu_result = alu_ref(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  logic [31:0] stk[$];
  logic [31:0] m_rd;
  logic        m_zero;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_done",  bus.done, 0);
    check("rst_err",   bus.err, 0);
    check("rst_depth", bus.depth, 0);
    check("rst_rd",    bus.rd_data, 0);
    check("rst_zero",  bus.zero_flag, 0);
    check("rst_aluop", alu_op, 0);
    check("rst_alua",  alu_a, 0);
    check("rst_alub",  alu_b, 0);
    reset_n = 1'b1;
    stk.delete();
    m_rd = '0;
    m_zero = 1'b0;
    @(negedge clk);
    check("rst_release_ready", bus.cmd_ready, 1);
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [31:0] data);
    logic        e_err, alu_ok, got;
    int          e_lat, lat;
    logic [31:0] a, b, r;
    a = '0; b = '0; alu_ok = 1'b0; got = 1'b0; lat = 0; e_lat = 1;
    e_err = !(op >= 4'd1 && op <= 4'd8) ||
            (op == OP_PUSH && stk.size() == DEPTH) ||
            (op == OP_POP && stk.size() == 0) ||
            (op >= OP_ADD && op <= OP_AND && stk.size() < 2);
    if (!e_err) begin
      if (op == OP_PUSH) stk.push_back(data);
      else if (op == OP_POP) m_rd = stk.pop_back();
      else begin
        b = stk.pop_back();
        a = stk.pop_back();
        r = alu_ref(op, a, b);
        stk.push_back(r);
        m_rd = r;
        m_zero = (r == 0);
        alu_ok = 1'b1;
        e_lat = 4;
      end
    end
    for (int i = 0; i < 10 && !bus.cmd_ready; i++) @(negedge clk);
    if (!bus.cmd_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'($urandom);
    bus.cmd_data  = $urandom;
    for (int c = 1; c <= 8; c++) begin
      lat = c;
      check("alu_op", alu_op, (alu_ok && c == 3) ? op : 4'd0);
      if (alu_ok && c == 3) begin
        check("alu_a", alu_a, a);
        check("alu_b", alu_b, b);
      end
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", got, 1);
    if (got) begin
      check("latency",   lat, e_lat);
      check("err",       bus.err, e_err);
      check("rd_data",   bus.rd_data, m_rd);
      check("zero_flag", bus.zero_flag, m_zero);
      check("depth",     bus.depth, stk.size());
      @(negedge clk);
      check("done_gap",    bus.done, 0);
      check("ready_after", bus.cmd_ready, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, nd, b2b;
    logic prev;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;

    // Basic ALU ops
    do_reset();
    do_cmd(OP_PUSH, 5);
    do_cmd(OP_PUSH, 3);
    do_cmd(OP_SUB, 0);
    do_cmd(OP_PUSH, 3);
    do_cmd(OP_PUSH, 5);
    do_cmd(OP_SLT, 0);
    do_cmd(OP_PUSH, 1);
    do_cmd(OP_SUB, 0);

    // Error cases on a short stack
    do_reset();
    do_cmd(OP_POP, 0);
    do_cmd(OP_PUSH, 7);
    do_cmd(OP_ADD, 0);
    do_cmd(4'hF, 0);
    do_cmd(4'h0, 0);

    // Fill, overflow, drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_cmd(OP_PUSH, i);
    do_cmd(OP_PUSH, 8);
    for (int i = 0; i < DEPTH; i++) do_cmd(OP_POP, 0);
    do_cmd(OP_POP, 0);

    // Continuous valid: one accept every two cycles
    do_reset();
    acc = 0; nd = 0; b2b = 0; prev = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_PUSH;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) begin
        nd++;
        if (prev) b2b++;
      end
      prev = bus.done;
      bus.cmd_data = 100 + i;
      if (bus.cmd_ready) begin
        acc++;
        stk.push_back(100 + i);
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("stream_accepts", acc, 4);
    check("stream_dones", nd, 4);
    check("stream_b2b", b2b, 0);
    check("stream_depth", bus.depth, stk.size());
    for (int i = 0; i < 4; i++) do_cmd(OP_POP, 0);

    // Reset during FETCH_A of an ADD
    do_cmd(OP_PUSH, 9);
    do_cmd(OP_PUSH, 4);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("abort_done_fb", bus.done, 0);
    @(negedge clk);
    check("abort_done_fa", bus.done, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_done_rst", bus.done, 0);
    reset_n = 1'b1;
    stk.delete();
    m_rd = '0;
    m_zero = 1'b0;
    @(negedge clk);
    check("abort_done_after", bus.done, 0);
    check("abort_ready", bus.cmd_ready, 1);
    check("abort_depth", bus.depth, 0);

    // Random commands
    for (int n = 0; n < 400; n++) begin
      int          sel;
      logic [3:0]  op;
      logic [31:0] d;
      sel = $urandom_range(0, 19);
      if (sel < 6)       op = OP_PUSH;
      else if (sel < 9)  op = OP_POP;
      else if (sel < 18) op = 4'(3 + (sel - 9) % 6);
      else if (sel == 18) op = 4'd0;
      else               op = 4'($urandom_range(9, 15));
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      do_cmd(op, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
